// File: rtl/name_entry_ctrl.sv
// Name-entry controller: takes keyboard characters, writes them into a 32-entry name memory,
// handles backspace/terminate. Optional upper-casing when NAME_ENTRY_UPPERCASE_EN is defined.
module name_entry_ctrl #(
  parameter logic [7:0] TERM_CHAR = 8'h0D,
  parameter logic [7:0] BS_CHAR   = 8'h08
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Start,
  input  logic [7:0] CharIn,
  input  logic       CharValid,
  output logic       CharReady,
  output logic [4:0] Addr,
  output logic [7:0] WriteData,
  output logic       WNM,
  output logic       InitNM,
  output logic [5:0] Length,
  output logic       Full,
  output logic       Done
);

  typedef enum logic [1:0] {IDLE, INIT, ACCEPT, DONE} state_e;

  state_e     state_q, state_d;
  logic [4:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       wnm_q, wnm_d;
  logic       initnm_q, initnm_d;
  logic [5:0] len_q, len_d;
  logic       done_q, done_d;
  logic [7:0] char_w;
  logic       printable;
  logic       full_w;

  assign CharReady = (state_q == ACCEPT) && !Start;
  assign full_w    = (len_q == 6'd32);
  assign printable = (CharIn >= 8'h20) && (CharIn <= 8'h7E);

  always_comb begin
    char_w = CharIn;
`ifdef NAME_ENTRY_UPPERCASE_EN
    if (CharIn >= 8'h61 && CharIn <= 8'h7A) char_w = CharIn - 8'h20;
`endif
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wnm_d    = 1'b0;
    initnm_d = 1'b0;
    len_d    = len_q;
    done_d   = done_q;
    case (state_q)
      // INIT always advances, so InitNM can only ever be a single-cycle pulse
      INIT: state_d = ACCEPT;
      default: begin
        if (Start) begin
          state_d  = INIT;
          initnm_d = 1'b1;
          len_d    = 6'd0;
          done_d   = 1'b0;
        end else if (CharValid && CharReady) begin
          if (CharIn == TERM_CHAR) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (CharIn == BS_CHAR) begin
            if (len_q != 6'd0) begin
              addr_d  = len_q[4:0] - 5'd1;
              wdata_d = 8'h00;
              wnm_d   = 1'b1;
              len_d   = len_q - 6'd1;
            end
          end else if (printable && !full_w) begin
            addr_d  = len_q[4:0];
            wdata_d = char_w;
            wnm_d   = 1'b1;
            len_d   = len_q + 6'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= IDLE;
      addr_q   <= 5'd0;
      wdata_q  <= 8'h00;
      wnm_q    <= 1'b0;
      initnm_q <= 1'b0;
      len_q    <= 6'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wnm_q    <= wnm_d;
      initnm_q <= initnm_d;
      len_q    <= len_d;
      done_q   <= done_d;
    end
  end

  assign Addr      = addr_q;
  assign WriteData = wdata_q;
  assign WNM       = wnm_q;
  assign InitNM    = initnm_q;
  assign Length    = len_q;
  assign Full      = full_w;
  assign Done      = done_q;

endmodule

// File: tb/tb_name_entry_ctrl.sv
// Scoreboard bench for name_entry_ctrl: a queue-of-characters model predicts memory strobes,
// a negedge monitor pops and compares them; per-cycle status checks run in the driver.
module tb_name_entry_ctrl;

  logic       Clk = 1'b0;
  logic       Rst, Start, CharValid;
  logic [7:0] CharIn;
  logic       CharReady, WNM, InitNM, Full, Done;
  logic [4:0] Addr;
  logic [7:0] WriteData;
  logic [5:0] Length;

  name_entry_ctrl dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .CharIn(CharIn), .CharValid(CharValid),
    .CharReady(CharReady), .Addr(Addr), .WriteData(WriteData), .WNM(WNM),
    .InitNM(InitNM), .Length(Length), .Full(Full), .Done(Done)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    bit         is_init;
    logic [4:0] a;
    logic [7:0] d;
  } ev_t;

  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  // reference model: mode 0 idle, 1 init, 2 accepting, 3 done
  int         m_mode = 0;
  byte        name_buf[$];
  logic [4:0] m_addr = '0;
  logic [7:0] m_data = '0;
  bit         m_done = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] stored(input logic [7:0] c);
`ifdef NAME_ENTRY_UPPERCASE_EN
    if (c >= 8'h61 && c <= 8'h7A) return c - 8'h20;
`endif
    return c;
  endfunction

  // one clock of stimulus: check status on the negedge, then advance the model at the posedge
  task automatic cyc(input logic rs, input logic st, input logic v, input logic [7:0] c);
    Rst = rs; Start = st; CharValid = v; CharIn = c;
    @(negedge Clk);
    chk("CharReady", CharReady, (m_mode == 2) && !st);
    chk("Length", Length, name_buf.size());
    chk("Full", Full, name_buf.size() == 32);
    chk("Done", Done, m_done);
    chk("Addr", Addr, m_addr);
    chk("WriteData", WriteData, m_data);
    @(posedge Clk);
    if (rs) begin
      m_mode = 0; name_buf.delete(); m_addr = '0; m_data = '0; m_done = 0;
    end else if (m_mode == 1) begin
      m_mode = 2;
    end else if (st) begin
      m_mode = 1; name_buf.delete(); m_done = 0;
      exp_q.push_back('{1'b1, 5'd0, 8'h00});
    end else if (m_mode == 2 && v) begin
      if (c == 8'h0D) begin
        m_mode = 3; m_done = 1;
      end else if (c == 8'h08) begin
        if (name_buf.size() > 0) begin
          void'(name_buf.pop_back());
          m_addr = 5'(name_buf.size()); m_data = 8'h00;
          exp_q.push_back('{1'b0, m_addr, m_data});
        end
      end else if (c >= 8'h20 && c <= 8'h7E && name_buf.size() < 32) begin
        m_addr = 5'(name_buf.size()); m_data = stored(c);
        name_buf.push_back(byte'(c));
        exp_q.push_back('{1'b0, m_addr, m_data});
      end
    end
    #1;
  endtask

  // monitor: every strobe the DUT shows must match the head of the expected queue
  always @(negedge Clk) begin
    if (WNM === 1'b1 || InitNM === 1'b1) begin
      chk("WNM_InitNM_exclusive", {31'd0, WNM && InitNM}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", {30'd0, WNM, InitNM}, 32'd0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("strobe_kind", {30'd0, WNM, InitNM}, e.is_init ? 32'd1 : 32'd2);
        if (!e.is_init) begin
          chk("wr_addr", Addr, e.a);
          chk("wr_data", WriteData, e.d);
        end
      end
    end
  end

  function automatic logic [7:0] rnd_char(input int bs_pct, input int term_pct);
    int r;
    r = $urandom_range(0, 99);
    if (r < bs_pct) return 8'h08;
    if (r < bs_pct + term_pct) return 8'h0D;
    if (r < bs_pct + term_pct + 8) return 8'($urandom_range(0, 31));
    if (r < bs_pct + term_pct + 12) return 8'($urandom_range(127, 255));
    if (r < bs_pct + term_pct + 25) return 8'($urandom_range(8'h61, 8'h7A));
    return 8'($urandom_range(8'h20, 8'h7E));
  endfunction

  initial begin
    Rst = 1'b1; Start = 1'b0; CharValid = 1'b0; CharIn = 8'h00;
    repeat (2) @(posedge Clk);
    #1;
    // reset state, then Start, 'A','B'
    cyc(1, 0, 0, 8'h00);
    cyc(0, 1, 0, 8'h00);
    cyc(0, 0, 0, 8'h00);
    cyc(0, 0, 1, 8'h41);
    cyc(0, 0, 1, 8'h42);
    // backspace then terminate
    cyc(0, 0, 1, 8'h08);
    cyc(0, 0, 1, 8'h0D);
    cyc(0, 0, 1, 8'h43);
    cyc(0, 0, 0, 8'h00);
    // fill past capacity
    cyc(0, 1, 0, 8'h00);
    cyc(0, 0, 0, 8'h00);
    for (int i = 0; i < 35; i++) cyc(0, 0, 1, 8'h78);
    cyc(0, 0, 1, 8'h08);
    cyc(0, 0, 0, 8'h00);
    // Start collides with a valid char
    cyc(0, 1, 1, 8'h51);
    cyc(0, 0, 1, 8'h51);
    cyc(0, 0, 0, 8'h00);
    // backspace on empty, unprintable, then reset mid-burst
    cyc(0, 0, 1, 8'h08);
    cyc(0, 0, 1, 8'h07);
    cyc(0, 0, 1, 8'h61);
    cyc(0, 0, 1, 8'h62);
    cyc(0, 0, 1, 8'h63);
    cyc(1, 0, 1, 8'h64);
    cyc(0, 0, 1, 8'h65);
    cyc(0, 0, 0, 8'h00);
    // randomized phases: general mix, then a fill-biased mix
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 1500; i++) begin
        int r;
        logic rs, st;
        r  = $urandom_range(0, 199);
        rs = (r < 2);
        st = (r >= 2 && r < (k == 0 ? 10 : 4));
        cyc(rs, st, $urandom_range(0, 3) != 0,
            rnd_char(k == 0 ? 15 : 4, k == 0 ? 5 : 1));
      end
    end
    cyc(0, 0, 0, 8'h00);
    cyc(0, 0, 0, 8'h00);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/name_entry_ctrl.md
NAME_ENTRY_CTRL -- requirements
Module: name_entry_ctrl

Interface
REQ-001 Parameter TERM_CHAR, default 8'h0D, character that ends entry.
REQ-002 Parameter BS_CHAR, default 8'h08, character that deletes the last stored character.
REQ-003 Port Clk  in  1  single clock; all logic on posedge Clk.
REQ-004 Port Rst  in  1  reset, synchronous and active-high.
REQ-005 Port Start  in  1  begin a new name entry; sampled every cycle.
REQ-006 Port CharIn  in  8  ASCII character from the keyboard stage.
REQ-007 Port CharValid  in  1  CharIn is valid this cycle.
REQ-008 Port CharReady  out  1  block accepts CharIn this cycle.
REQ-009 Port Addr  out  5  name-memory address.
REQ-010 Port WriteData  out  8  name-memory write data.
REQ-011 Port WNM  out  1  name-memory write strobe.
REQ-012 Port InitNM  out  1  name-memory clear strobe.
REQ-013 Port Length  out  6  stored character count, 0..32.
REQ-014 Port Full  out  1  Length == 32.
REQ-015 Port Done  out  1  entry terminated; level until next Start or Rst.

Function
REQ-016 States: IDLE, INIT, ACCEPT, DONE.
REQ-017 IDLE/ACCEPT/DONE with Start=1 -> INIT; otherwise hold.
REQ-018 INIT: InitNM=1 for exactly one cycle, Length<=0, Done<=0, next state ACCEPT.
REQ-019 CharReady = (state==ACCEPT) && !Start, combinational; a handshake completes on CharValid && CharReady.
REQ-020 Start and CharValid in the same ACCEPT cycle: Start wins, character not consumed.
REQ-021 Accepted printable char (8'h20..8'h7E), Length<32: next edge Addr<=Length[4:0], WriteData<=char, WNM<=1, Length<=Length+1.
REQ-022 Accepted printable char when Full: dropped, no write, Length unchanged, CharReady stays 1.
REQ-023 Accepted BS_CHAR, Length>0: Addr<=Length-1, WriteData<=8'h00, WNM<=1, Length<=Length-1.
REQ-024 Accepted BS_CHAR, Length==0: ignored, no write.
REQ-025 Accepted TERM_CHAR: no write, state->DONE, Done<=1 on the same edge.
REQ-026 Any other accepted char: consumed, ignored.
REQ-027 Addr, WriteData, WNM, InitNM registered; WNM and InitNM are one-cycle pulses, never asserted together.
REQ-028 Outside a write cycle WNM=0; Addr and WriteData hold their last values.
REQ-029 Full = (Length==6'd32), combinational from registered Length.
REQ-030 Throughput: one character per cycle sustained in ACCEPT.

Reset
REQ-031 Rst=1 at a posedge: state<=IDLE, Addr<=0, WriteData<=0, WNM<=0, InitNM<=0, Length<=0, Done<=0.
REQ-032 Rst overrides Start and any in-flight handshake; no write strobe is issued in the cycle after reset.
REQ-033 Rst asserted mid-entry discards the entry; the block does not clear the name memory itself, and the memory's own reset does.

Configuration
REQ-034 Macro NAME_ENTRY_UPPERCASE_EN defined: accepted chars 8'h61..8'h7A are written as char-8'h20.
REQ-035 Macro NAME_ENTRY_UPPERCASE_EN undefined: printable chars are written unchanged.

Verification
REQ-036 Rst, Start, then 'A','B' each with CharValid=1 -> InitNM pulse, then WNM at Addr 0 data 8'h41 and Addr 1 data 8'h42, Length=2.
REQ-037 After 'A','B' send BS_CHAR, then 8'h0D -> WNM at Addr 1 data 8'h00, Length=1, Done=1, CharReady=0.
REQ-038 35 consecutive 'x' chars -> 32 writes at Addr 0..31, Full=1, last 3 dropped, Length=32, CharReady=1 throughout.
REQ-039 Start and CharValid='Q' in the same ACCEPT cycle -> no write, InitNM pulse next cycle, Length=0.
REQ-040 Rst during a 5-char burst after the 3rd char -> all outputs 0 next cycle, state IDLE, CharReady=0; 'a' with NAME_ENTRY_UPPERCASE_EN defined -> WriteData 8'h41, with it undefined -> 8'h61.
